// File: rtl/mem_bridge.sv
// ---------------------------------------------------------------------------
// mem_bridge
//   Memory interface stage that sits behind the multicycle controller. It turns
//   the controller's one-cycle mem_read / mem_write / IorD strobes into a
//   req/ack transaction on a slow, single-ported unified memory. It returns read
//   data to the datapath and holds mem_busy high, so the controller stalls until
//   the access completes.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a REQ cycle counter abandons an access that has not been
//   acknowledged after TIMEOUT cycles. The access still completes with a done
//   pulse and raises err. When undefined, REQ waits for m_ack indefinitely.
//
// Parameters
//   ADDR_W   address width (byte address, word aligned)
//   DATA_W   data word width
//   TIMEOUT  maximum REQ cycles without m_ack (MEM_TIMEOUT_EN only), >= 2
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   mem_read/mem_write controller strobes (write wins if both are high)
//   IorD               0: use pc_addr (fetch), 1: use alu_addr (data)
//   pc_addr, alu_addr  candidate addresses
//   wdata              store data
//   rdata              registered read data, held until the next read completes
//   mem_busy           stall to controller (combinational)
//   done               one-cycle completion pulse
//   err                sticky error (misaligned address, or timeout)
//   m_req/m_we/m_addr/m_wdata  memory request side, stable while m_req is high
//   m_rdata/m_ack      memory response, m_ack is a one-cycle pulse
//   o_dbg_state        current FSM state, for debug and checkers
//
// Handshake: m_req rises in the cycle after a strobe is accepted. m_addr, m_we
// and m_wdata then stay constant until a clock edge that samples m_ack=1. That
// edge drops m_req. m_ack is only looked at while in REQ; at any other time it
// is ignored.
// ---------------------------------------------------------------------------
module mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              IorD,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_busy,
  output logic              done,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;
  logic              r_err;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;

  logic              w_start;
  logic [ADDR_W-1:0] w_addr;

  assign w_start = mem_read | mem_write;
  assign w_addr  = IorD ? alu_addr : pc_addr;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
`else
  // TIMEOUT only matters when the timeout feature is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_m_addr  <= w_addr;
            r_m_wdata <= wdata;
            r_m_we    <= mem_write;
            // A misaligned access never reaches the memory. It still finishes
            // with a done pulse, so the controller is not left stalled.
            if (w_addr[1:0] != 2'b00) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_m_req <= 1'b1;
              r_state <= S_REQ;
`ifdef MEM_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
        end

        S_REQ: begin
          if (m_ack) begin
            if (!r_m_we) begin
              r_rdata <= m_rdata;
            end
            r_m_req <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          // r_cnt counts the REQ cycles already spent. TIMEOUT-1 means this is
          // the TIMEOUT-th REQ cycle.
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_m_req <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          // Strobes arriving here are left for the following IDLE cycle.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_m_req <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The stall has to be seen in the strobe cycle itself, so in IDLE it follows
  // the strobe combinationally. It drops in DONE so the controller advances on
  // the same edge that ends the done pulse.
  always_comb begin
    mem_busy = 1'b0;
    case (r_state)
      S_IDLE:  mem_busy = w_start;
      S_REQ:   mem_busy = 1'b1;
      S_DONE:  mem_busy = 1'b0;
      default: mem_busy = 1'b0;
    endcase
  end

  assign rdata       = r_rdata;
  assign done        = r_done;
  assign err         = r_err;
  assign m_req       = r_m_req;
  assign m_we        = r_m_we;
  assign m_addr      = r_m_addr;
  assign m_wdata     = r_m_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bridge
//   Directed test bench for mem_bridge. Each task runs one scenario on a fixed
//   cycle schedule and compares the outputs with hand-computed values. Inputs
//   change 2 ns after a rising edge. Registered outputs are compared at that
//   point; combinational mem_busy is compared 1 ns after the inputs change.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic              mem_write;
  logic              IorD;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_busy;
  logic              done;
  logic              err;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic [1:0]        dbg_state;

  int checks;
  int errors;

  mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .IorD(IorD), .pc_addr(pc_addr), .alu_addr(alu_addr), .wdata(wdata),
    .rdata(rdata), .mem_busy(mem_busy), .done(done), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .o_dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 0; mem_write = 0; IorD = 0;
    pc_addr = '0; alu_addr = '0; wdata = '0; m_rdata = '0; m_ack = 0;
    step(); step();
    checks++; if ({rdata, done, err, m_req, m_we, m_addr, m_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got rdata=%h done=%b err=%b req=%b we=%b addr=%h wd=%h required all 0",
                          rdata, done, err, m_req, m_we, m_addr, m_wdata);
    end
    checks++; if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d required %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    // cycle 0: strobe
    IorD = 0; pc_addr = 32'h40; mem_read = 1;
    #1;
    checks++; if (mem_busy !== 1'b1) begin
      errors++; $display("FAIL fetch_busy_c0 got %b required 1", mem_busy);
    end
    step(); mem_read = 0; // cycle 1
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0) begin
      errors++; $display("FAIL fetch_req got req=%b addr=%h we=%b required 1/00000040/0", m_req, m_addr, m_we);
    end
    checks++; if (mem_busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL fetch_busy_c1 got busy=%b done=%b required 1/0", mem_busy, done);
    end
    step(); // cycle 2: ack
    m_ack = 1; m_rdata = 32'h8C820004;
    #1;
    checks++; if (mem_busy !== 1'b1 || m_req !== 1'b1) begin
      errors++; $display("FAIL fetch_busy_c2 got busy=%b req=%b required 1/1", mem_busy, m_req);
    end
    step(); m_ack = 0; m_rdata = '0; // cycle 3
    checks++; if (done !== 1'b1 || mem_busy !== 1'b0 || m_req !== 1'b0) begin
      errors++; $display("FAIL fetch_done got done=%b busy=%b req=%b required 1/0/0", done, mem_busy, m_req);
    end
    checks++; if (rdata !== 32'h8C820004) begin
      errors++; $display("FAIL fetch_rdata got %h required 8c820004", rdata);
    end
    step(); // cycle 4
    checks++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL fetch_end got done=%b state=%0d required 0/0", done, dbg_state);
    end
  endtask

  task automatic test_store();
    IorD = 1; alu_addr = 32'h100; wdata = 32'hDEADBEEF; mem_write = 1;
    step(); mem_write = 0; wdata = 32'h0; alu_addr = 32'h0;
    // REQ cycles 1..4 are wait cycles, and m_ack comes in cycle 5.
    for (int c = 1; c <= 5; c++) begin
      checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF || m_addr !== 32'h100 || done !== 1'b0) begin
        errors++; $display("FAIL store_hold_c%0d got req=%b we=%b wd=%h addr=%h done=%b required 1/1/deadbeef/00000100/0",
                            c, m_req, m_we, m_wdata, m_addr, done);
      end
      if (c < 5) step();
    end
    m_ack = 1; m_rdata = 32'h12345678;
    step(); m_ack = 0; m_rdata = '0; // cycle 6
    checks++; if (done !== 1'b1 || m_req !== 1'b0) begin
      errors++; $display("FAIL store_done got done=%b req=%b required 1/0", done, m_req);
    end
    checks++; if (rdata !== 32'h8C820004) begin
      errors++; $display("FAIL store_rdata got %h required 8c820004", rdata);
    end
    step(); // cycle 7
    checks++; if (done !== 1'b0) begin
      errors++; $display("FAIL store_single_pulse got done=%b required 0", done);
    end
  endtask

  task automatic test_back_to_back();
    IorD = 1; alu_addr = 32'h8; wdata = 32'h55; mem_read = 1; mem_write = 1;
    step(); mem_read = 0; mem_write = 0; // cycle 1: zero-wait ack
    checks++; if (m_we !== 1'b1 || m_addr !== 32'h8 || m_req !== 1'b1 || m_wdata !== 32'h55) begin
      errors++; $display("FAIL both_write got we=%b addr=%h req=%b wd=%h required 1/00000008/1/00000055", m_we, m_addr, m_req, m_wdata);
    end
    m_ack = 1;
    step(); m_ack = 0; // cycle 2: DONE, present a new read
    IorD = 0; pc_addr = 32'h44; mem_read = 1;
    #1;
    checks++; if (done !== 1'b1 || mem_busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_done got done=%b busy=%b err=%b required 1/0/0", done, mem_busy, err);
    end
    step(); // cycle 3: IDLE accepts the held strobe
    checks++; if (dbg_state !== ST_IDLE || m_req !== 1'b0 || done !== 1'b0 || mem_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_idle got state=%0d req=%b done=%b busy=%b required 0/0/0/1", dbg_state, m_req, done, mem_busy);
    end
    step(); mem_read = 0; // cycle 4
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h44 || m_we !== 1'b0) begin
      errors++; $display("FAIL b2b_read got req=%b addr=%h we=%b required 1/00000044/0", m_req, m_addr, m_we);
    end
    m_ack = 1; m_rdata = 32'hCAFEF00D;
    step(); m_ack = 0; m_rdata = '0; // cycle 5
    checks++; if (done !== 1'b1 || rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_rdata got done=%b rdata=%h required 1/cafef00d", done, rdata);
    end
    step();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    IorD = 1; alu_addr = 32'h200; mem_read = 1;
    step(); mem_read = 0;
    // REQ cycles 1..16 keep m_req high, and m_req drops in cycle 17.
    for (int c = 1; c <= 16; c++) begin
      checks++; if (m_req !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL timeout_wait_c%0d got req=%b err=%b done=%b required 1/0/0", c, m_req, err, done);
      end
      step();
    end
    checks++; if (m_req !== 1'b0 || err !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL timeout_fire got req=%b err=%b done=%b required 0/1/1", m_req, err, done);
    end
    checks++; if (rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL timeout_rdata got %h required cafef00d", rdata);
    end
    step();
  endtask
`else
  task automatic test_long_wait();
    IorD = 1; alu_addr = 32'h200; mem_read = 1;
    step(); mem_read = 0;
    for (int c = 1; c <= 20; c++) step();
    checks++; if (m_req !== 1'b1 || err !== 1'b0 || mem_busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL long_wait got req=%b err=%b busy=%b done=%b required 1/0/1/0", m_req, err, mem_busy, done);
    end
    m_ack = 1; m_rdata = 32'hA5A5A5A5;
    step(); m_ack = 0; m_rdata = '0;
    checks++; if (done !== 1'b1 || rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL long_wait_done got done=%b rdata=%h required 1/a5a5a5a5", done, rdata);
    end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    IorD = 0; pc_addr = 32'h80; mem_read = 1;
    step(); mem_read = 0;
    checks++; if (m_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_req_before got %b required 1", m_req);
    end
    rst = 1'b0;
    #1;
    checks++; if ({rdata, done, err, m_req, m_we, m_addr, m_wdata} !== '0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got rdata=%h done=%b err=%b req=%b we=%b addr=%h wd=%h busy=%b required all 0",
                          rdata, done, err, m_req, m_we, m_addr, m_wdata, mem_busy);
    end
    step(); rst = 1'b1;
    step(); // spurious ack while IDLE
    m_ack = 1; m_rdata = 32'hFFFFFFFF;
    step(); m_ack = 0; m_rdata = '0;
    checks++; if (dbg_state !== ST_IDLE || rdata !== '0 || done !== 1'b0 || m_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_spurious_ack got state=%0d rdata=%h done=%b req=%b required 0/00000000/0/0",
                          dbg_state, rdata, done, m_req);
    end
  endtask

  task automatic test_misaligned();
    IorD = 1; alu_addr = 32'h102; pc_addr = 32'h0; mem_read = 1;
    #1;
    checks++; if (mem_busy !== 1'b1) begin
      errors++; $display("FAIL misalign_busy got %b required 1", mem_busy);
    end
    step(); mem_read = 0; // cycle 1
    checks++; if (m_req !== 1'b0 || err !== 1'b1 || done !== 1'b1 || dbg_state !== ST_DONE) begin
      errors++; $display("FAIL misalign_done got req=%b err=%b done=%b state=%0d required 0/1/1/2", m_req, err, done, dbg_state);
    end
    step(); // cycle 2
    checks++; if (m_req !== 1'b0 || err !== 1'b1 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL misalign_sticky got req=%b err=%b done=%b state=%0d required 0/1/0/0", m_req, err, done, dbg_state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
